// File: rtl/uart_alu_pkg.sv
// Shared types for the byte-stream ALU: opcodes, FSM states and
// the opcode classifier used by the top-level decoder.
package uart_alu_pkg;

    typedef logic [7:0] opcode_t;

    localparam opcode_t OP_ADD = 8'hA0;
    localparam opcode_t OP_SUB = 8'hA1;
    localparam opcode_t OP_AND = 8'hA2;
    localparam opcode_t OP_OR  = 8'hA3;
    localparam opcode_t OP_XOR = 8'hA4;
    localparam opcode_t OP_MUL = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        SEND_HI,
        SEND
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b >= OP_ADD) && (b <= OP_MUL);
    endfunction

endpackage

// File: rtl/uart_alu_exec.sv
// Combinational 8-bit ALU; MUL yields a 16-bit product and flags
// that both result bytes must be sent.
module alu_exec
    import uart_alu_pkg::*;
(
    input  opcode_t     op,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] result,
    output logic        two_byte
);

    logic [7:0]  sum;
    logic [7:0]  diff;
    logic [15:0] prod;

    assign sum  = a + b;
    assign diff = a - b;
    assign prod = {8'h00, a} * {8'h00, b};

    always_comb begin
        result   = 16'h0000;
        two_byte = 1'b0;
        case (op)
            OP_ADD: result = {8'h00, sum};
            OP_SUB: result = {8'h00, diff};
            OP_AND: result = {8'h00, a & b};
            OP_OR:  result = {8'h00, a | b};
            OP_XOR: result = {8'h00, a ^ b};
            OP_MUL: begin
                result   = prod;
                two_byte = 1'b1;
            end
            default: result = 16'h0000;
        endcase
    end

endmodule

// File: rtl/uart_alu.sv
// Byte-stream ALU: echoes plain bytes, executes opcode + two operands
// and returns the result over a single-entry output register.
module uart_alu
    import uart_alu_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i
);

    state_t     state;
    opcode_t    op;
    logic [7:0] a;
    logic [7:0] lo;

    logic [15:0] result;
    logic        two_byte;
    logic        take;

    assign take = valid_i && ready_o;

    // Operand B feeds the ALU straight from the input so the result
    // is registered on the same edge that accepts it.
    alu_exec u_exec (
        .op       (op),
        .a        (a),
        .b        (data_i),
        .result   (result),
        .two_byte (two_byte)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            op      <= '0;
            a       <= '0;
            lo      <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            ready_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    ready_o <= 1'b1;
                    if (take) begin
                        if (is_opcode(data_i)) begin
                            op    <= data_i;
                            state <= GET_A;
                        end else begin
                            data_o  <= data_i;
                            valid_o <= 1'b1;
                            ready_o <= 1'b0;
                            state   <= SEND;
                        end
                    end
                end
                GET_A: begin
                    if (take) begin
                        a     <= data_i;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (take) begin
                        valid_o <= 1'b1;
                        ready_o <= 1'b0;
                        if (two_byte) begin
                            data_o <= result[15:8];
                            lo     <= result[7:0];
                            state  <= SEND_HI;
                        end else begin
                            data_o <= result[7:0];
                            state  <= SEND;
                        end
                    end
                end
                SEND_HI: begin
                    if (ready_i) begin
                        data_o <= lo;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu.sv
// Directed self-checking bench for uart_alu: echo, ALU commands,
// backpressure and mid-command reset.
module tb_uart_alu;

    logic       clk_i;
    logic       rst_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       two;
        logic [7:0] r0;
        logic [7:0] r1;
        int         gap;
        string      name;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] echoes[5];

    uart_alu dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk_i);
        n = 0;
        while (!ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!ready_o) check("send_timeout", {7'd0, ready_o}, 8'h01);
        data_i  = b;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        data_i  = 8'($urandom);
    endtask

    // Output must be valid on the first sample after it is produced.
    task automatic recv_byte(input string name, input logic [7:0] exp);
        @(negedge clk_i);
        check({name, "_valid"}, {7'd0, valid_o}, 8'h01);
        check({name, "_ready_low"}, {7'd0, ready_o}, 8'h00);
        check({name, "_data"}, data_o, exp);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk_i);
        check({name, "_valid_clr"}, {7'd0, valid_o}, 8'h00);
        check({name, "_ready_set"}, {7'd0, ready_o}, 8'h01);
    endtask

    initial begin
        vecs[0] = '{8'hA0, 8'hF0, 8'h20, 1'b0, 8'h10, 8'h00, 0, "add_wrap"};
        vecs[1] = '{8'hA1, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h00, 0, "sub_wrap"};
        vecs[2] = '{8'hA5, 8'hFF, 8'hFF, 1'b1, 8'hFE, 8'h01, 0, "mul_max"};
        vecs[3] = '{8'hA4, 8'hA0, 8'h0F, 1'b0, 8'hAF, 8'h00, 0, "xor_opval"};
        vecs[4] = '{8'hA2, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 3, "and_gap"};
        vecs[5] = '{8'hA3, 8'h0F, 8'h30, 1'b0, 8'h3F, 8'h00, 0, "or"};
        vecs[6] = '{8'hA5, 8'h03, 8'h05, 1'b1, 8'h00, 8'h0F, 2, "mul_small"};
        vecs[7] = '{8'hA0, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 0, "add_zero"};
        vecs[8] = '{8'hA1, 8'h10, 8'hA5, 1'b0, 8'h6B, 8'h00, 0, "sub_opval"};
        echoes  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hE7};

        rst_i   = 1'b1;
        data_i  = 8'h00;
        valid_i = 1'b0;
        ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_valid", {7'd0, valid_o}, 8'h00);
        check("rst_data", data_o, 8'h00);
        check("rst_ready", {7'd0, ready_o}, 8'h00);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_ready_rise", {7'd0, ready_o}, 8'h01);

        foreach (echoes[i]) begin
            send_byte(echoes[i]);
            recv_byte($sformatf("echo%0d", i), echoes[i]);
            check_idle($sformatf("echo%0d", i));
        end

        for (int i = 0; i < 9; i++) begin
            send_byte(vecs[i].op);
            repeat (vecs[i].gap) begin
                @(negedge clk_i);
                data_i = 8'($urandom);
            end
            send_byte(vecs[i].a);
            repeat (vecs[i].gap) @(negedge clk_i);
            send_byte(vecs[i].b);
            recv_byte({vecs[i].name, "_b0"}, vecs[i].r0);
            if (vecs[i].two)
                recv_byte({vecs[i].name, "_b1"}, vecs[i].r1);
            check_idle(vecs[i].name);
        end

        send_byte(8'h5A);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            check("bp_data", data_o, 8'h5A);
            check("bp_valid", {7'd0, valid_o}, 8'h01);
            check("bp_ready", {7'd0, ready_o}, 8'h00);
        end
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        check_idle("bp");
        @(negedge clk_i);
        check("bp_single", {7'd0, valid_o}, 8'h00);

        send_byte(8'hA0);
        send_byte(8'h05);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("mid_rst_valid", {7'd0, valid_o}, 8'h00);
        check("mid_rst_data", data_o, 8'h00);
        check("mid_rst_ready", {7'd0, ready_o}, 8'h00);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_rst_ready_rise", {7'd0, ready_o}, 8'h01);
        send_byte(8'h07);
        recv_byte("post_rst_echo", 8'h07);
        check_idle("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
